// File: rtl/router_pkg.sv
// Shared definitions for the router port sink: header field layout, FSM states
// and the payload beat carried through the skid buffer.
package router_pkg;

   localparam int unsigned DATA_W   = 8;
   localparam int unsigned LEN_MSB  = 7;
   localparam int unsigned LEN_LSB  = 2;
   localparam int unsigned ADDR_MSB = 1;
   localparam int unsigned ADDR_LSB = 0;
   localparam int unsigned LEN_W    = LEN_MSB - LEN_LSB + 1;
   localparam int unsigned ADDR_W   = ADDR_MSB - ADDR_LSB + 1;

   typedef enum logic [1:0] {
      S_HEADER  = 2'd0,
      S_PAYLOAD = 2'd1,
      S_PARITY  = 2'd2
   } state_e;

   typedef struct packed {
      logic              last;
      logic [DATA_W-1:0] data;
   } beat_t;

endpackage

// File: rtl/sink_skid_fifo.sv
// Two-entry {last, data} buffer between the frame parser and the payload stream.
module sink_skid_fifo
   import router_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  beat_t      push_beat,
   input  logic       pop,
   output beat_t      head,
   output logic [1:0] count
);

   beat_t mem [2];
   logic  wr_ptr;
   logic  rd_ptr;

   always_ff @(posedge clk) begin
      if (!reset) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_beat;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/router_packet_sink.sv
// Drains one router output port FIFO, parses {header, payload, parity} frames,
// streams payload downstream and reports per-packet status and error counts.
module router_packet_sink
   import router_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 32,
   parameter int unsigned CNT_WIDTH      = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_Output_Valid_Data,
   input  logic [DATA_W-1:0]    i_Output_Data,
   output logic                 o_Sig_Read_Enable,
   output logic [DATA_W-1:0]    o_Payload_Data,
   output logic                 o_Payload_Valid,
   output logic                 o_Payload_Last,
   input  logic                 i_Payload_Ready,
   output logic                 o_Packet_Done,
   output logic [ADDR_W-1:0]    o_Packet_Addr,
   output logic [LEN_W-1:0]     o_Packet_Length,
   output logic                 o_Parity_Error,
   output logic                 o_Timeout_Error,
   output logic [CNT_WIDTH-1:0] o_Packet_Count,
   output logic [CNT_WIDTH-1:0] o_Error_Count
);

   localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);

   state_e               state_q, state_d;
   logic [LEN_W-1:0]     len_q, len_d, cnt_q, cnt_d, stat_len_d;
   logic [ADDR_W-1:0]    addr_q, addr_d, stat_addr_d;
   logic [DATA_W-1:0]    par_q, par_d;
   logic [TMR_W-1:0]     timer_q, timer_d;
   logic                 rd_pending;
   logic [1:0]           buf_count;
   logic                 pop, push;
   beat_t                push_beat, head;
   logic [2:0]           occupancy;
   logic                 expire;
   logic                 done_d, perr_d, terr_d;
   logic [CNT_WIDTH-1:0] pkt_cnt_d, err_cnt_d, pkt_inc, err_inc;

   sink_skid_fifo u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_beat (push_beat),
      .pop       (pop),
      .head      (head),
      .count     (buf_count)
   );

   assign o_Payload_Valid = (buf_count != 2'd0);
   assign o_Payload_Data  = head.data;
   assign o_Payload_Last  = head.last;
   assign pop             = o_Payload_Valid && i_Payload_Ready;

   // A same-cycle pop frees its slot, so a draining buffer keeps reads back-to-back.
   assign occupancy         = 3'(buf_count) - 3'(pop) + 3'(rd_pending);
   assign o_Sig_Read_Enable = i_Output_Valid_Data && reset && (occupancy < 3'd2);

   assign pkt_inc = (o_Packet_Count == '1) ? o_Packet_Count : o_Packet_Count + CNT_WIDTH'(1);
   assign err_inc = (o_Error_Count  == '1) ? o_Error_Count  : o_Error_Count  + CNT_WIDTH'(1);
   assign expire  = !rd_pending && (state_q != S_HEADER)
                    && (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      addr_d      = addr_q;
      par_d       = par_q;
      cnt_d       = cnt_q;
      timer_d     = timer_q;
      done_d      = 1'b0;
      stat_addr_d = o_Packet_Addr;
      stat_len_d  = o_Packet_Length;
      perr_d      = o_Parity_Error;
      terr_d      = o_Timeout_Error;
      pkt_cnt_d   = o_Packet_Count;
      err_cnt_d   = o_Error_Count;
      push        = 1'b0;
      push_beat   = '0;

      // timer holds cycles elapsed since the most recent arrival
      if (rd_pending) begin
         timer_d = TMR_W'(1);
      end else if (state_q != S_HEADER) begin
         timer_d = timer_q + TMR_W'(1);
      end

      case (state_q)
         S_HEADER: begin
            if (rd_pending) begin
               len_d   = i_Output_Data[LEN_MSB:LEN_LSB];
               addr_d  = i_Output_Data[ADDR_MSB:ADDR_LSB];
               par_d   = i_Output_Data;
               cnt_d   = '0;
               state_d = (i_Output_Data[LEN_MSB:LEN_LSB] == '0) ? S_PARITY : S_PAYLOAD;
            end
         end
         S_PAYLOAD: begin
            if (rd_pending) begin
               par_d          = par_q ^ i_Output_Data;
               push           = 1'b1;
               push_beat.data = i_Output_Data;
               push_beat.last = (cnt_q == len_q - LEN_W'(1));
               cnt_d          = cnt_q + LEN_W'(1);
               if (push_beat.last) begin
                  state_d = S_PARITY;
               end
            end
         end
         S_PARITY: begin
            if (rd_pending) begin
               done_d      = 1'b1;
               stat_addr_d = addr_q;
               stat_len_d  = len_q;
               perr_d      = (i_Output_Data != par_q);
               terr_d      = 1'b0;
               if (perr_d) begin
                  err_cnt_d = err_inc;
               end else begin
                  pkt_cnt_d = pkt_inc;
               end
               state_d = S_HEADER;
            end
         end
         default: state_d = S_HEADER;
      endcase

      // abort a stalled packet; already-buffered bytes still drain
      if (expire) begin
         done_d      = 1'b1;
         stat_addr_d = addr_q;
         stat_len_d  = len_q;
         perr_d      = 1'b0;
         terr_d      = 1'b1;
         err_cnt_d   = err_inc;
         state_d     = S_HEADER;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q         <= S_HEADER;
         len_q           <= '0;
         addr_q          <= '0;
         par_q           <= '0;
         cnt_q           <= '0;
         timer_q         <= '0;
         rd_pending      <= 1'b0;
         o_Packet_Done   <= 1'b0;
         o_Packet_Addr   <= '0;
         o_Packet_Length <= '0;
         o_Parity_Error  <= 1'b0;
         o_Timeout_Error <= 1'b0;
         o_Packet_Count  <= '0;
         o_Error_Count   <= '0;
      end else begin
         state_q         <= state_d;
         len_q           <= len_d;
         addr_q          <= addr_d;
         par_q           <= par_d;
         cnt_q           <= cnt_d;
         timer_q         <= timer_d;
         rd_pending      <= o_Sig_Read_Enable;
         o_Packet_Done   <= done_d;
         o_Packet_Addr   <= stat_addr_d;
         o_Packet_Length <= stat_len_d;
         o_Parity_Error  <= perr_d;
         o_Timeout_Error <= terr_d;
         o_Packet_Count  <= pkt_cnt_d;
         o_Error_Count   <= err_cnt_d;
      end
   end

endmodule

// File: tb/tb_router_packet_sink.sv
// Directed bench for router_packet_sink: models the router port FIFO and checks
// payload stream, packet status, counters, timeout and reset recovery.
module tb_router_packet_sink;
   import router_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_Output_Valid_Data;
   logic [7:0]  i_Output_Data;
   logic        o_Sig_Read_Enable;
   logic [7:0]  o_Payload_Data;
   logic        o_Payload_Valid;
   logic        o_Payload_Last;
   logic        i_Payload_Ready;
   logic        o_Packet_Done;
   logic [1:0]  o_Packet_Addr;
   logic [5:0]  o_Packet_Length;
   logic        o_Parity_Error;
   logic        o_Timeout_Error;
   logic [15:0] o_Packet_Count;
   logic [15:0] o_Error_Count;

   always #5 clk = ~clk;

   router_packet_sink #(.TIMEOUT_CYCLES(32), .CNT_WIDTH(16)) dut (
      .clk                 (clk),
      .reset               (reset),
      .i_Output_Valid_Data (i_Output_Valid_Data),
      .i_Output_Data       (i_Output_Data),
      .o_Sig_Read_Enable   (o_Sig_Read_Enable),
      .o_Payload_Data      (o_Payload_Data),
      .o_Payload_Valid     (o_Payload_Valid),
      .o_Payload_Last      (o_Payload_Last),
      .i_Payload_Ready     (i_Payload_Ready),
      .o_Packet_Done       (o_Packet_Done),
      .o_Packet_Addr       (o_Packet_Addr),
      .o_Packet_Length     (o_Packet_Length),
      .o_Parity_Error      (o_Parity_Error),
      .o_Timeout_Error     (o_Timeout_Error),
      .o_Packet_Count      (o_Packet_Count),
      .o_Error_Count       (o_Error_Count)
   );

   typedef struct {
      int         cyc;
      logic [1:0] addr;
      logic [5:0] len;
      logic       perr;
      logic       terr;
   } done_t;

   typedef struct {
      logic [7:0] hdr;
      int         n;
      logic [7:0] par_flip;
      int         rmode;
      logic [1:0] ea;
      logic [5:0] el;
      logic       ep;
      int         epkt;
      int         eerr;
   } vec_t;

   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;
   logic [7:0] rq[$];
   logic [8:0] beats[$];
   done_t      dones[$];
   vec_t       vt[6];
   bit         src_en = 1'b0;
   bit         rst_drv = 1'b0;
   bit         prev_rden = 1'b0;
   int         ready_mode = 0;
   int         last_arr = 0;
   int         rd_run, rd_max, rd_total, f_max, f_viol;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // One clock: drive inputs just after the rising edge, observe at the falling edge.
   task automatic step();
      int    fc;
      done_t d;
      @(posedge clk);
      #1;
      cyc++;
      reset = rst_drv;
      if (prev_rden && rq.size() != 0) begin
         i_Output_Data = rq.pop_front();
         last_arr      = cyc;
      end
      i_Output_Valid_Data = src_en && (rq.size() != 0);
      i_Payload_Ready     = (ready_mode == 0) ? 1'b1 : 1'(cyc % 2);
      @(negedge clk);
      prev_rden = o_Sig_Read_Enable;
      if (o_Payload_Valid && i_Payload_Ready) beats.push_back({o_Payload_Last, o_Payload_Data});
      if (o_Packet_Done) begin
         d.cyc = cyc; d.addr = o_Packet_Addr; d.len = o_Packet_Length;
         d.perr = o_Parity_Error; d.terr = o_Timeout_Error;
         dones.push_back(d);
      end
      if (o_Sig_Read_Enable) begin
         rd_run++; rd_total++;
         if (rd_run > rd_max) rd_max = rd_run;
      end else begin
         rd_run = 0;
      end
      fc = int'(dut.u_fifo.count);
      if (fc > f_max) f_max = fc;
      if (fc == 2 && !i_Payload_Ready && o_Sig_Read_Enable) f_viol++;
   endtask

   task automatic clear_mon();
      beats.delete(); dones.delete();
      rd_run = 0; rd_max = 0; rd_total = 0; f_max = 0; f_viol = 0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_rden"},  32'(o_Sig_Read_Enable), 0);
      check({tag, "_pvld"},  32'(o_Payload_Valid), 0);
      check({tag, "_pdata"}, 32'(o_Payload_Data), 0);
      check({tag, "_plast"}, 32'(o_Payload_Last), 0);
      check({tag, "_done"},  32'(o_Packet_Done), 0);
      check({tag, "_addr"},  32'(o_Packet_Addr), 0);
      check({tag, "_len"},   32'(o_Packet_Length), 0);
      check({tag, "_perr"},  32'(o_Parity_Error), 0);
      check({tag, "_terr"},  32'(o_Timeout_Error), 0);
      check({tag, "_pcnt"},  32'(o_Packet_Count), 0);
      check({tag, "_ecnt"},  32'(o_Error_Count), 0);
   endtask

   task automatic run_vec(input int i);
      vec_t       v;
      logic [7:0] par;
      logic [7:0] b;
      logic [7:0] pl[$];
      string      t;
      v = vt[i];
      t = $sformatf("v%0d", i);
      par = v.hdr;
      rq.push_back(v.hdr);
      for (int k = 0; k < v.n; k++) begin
         b = 8'($urandom_range(0, 255));
         pl.push_back(b);
         par ^= b;
         rq.push_back(b);
      end
      rq.push_back(par ^ v.par_flip);
      clear_mon();
      ready_mode = v.rmode;
      src_en = 1'b1;
      for (int c = 0; c < 300; c++) begin
         step();
         if (dones.size() != 0 && beats.size() >= v.n && rq.size() == 0) break;
      end
      repeat (4) step();
      check({t, "_done_count"}, 32'(dones.size()), 1);
      if (dones.size() != 0) begin
         check({t, "_addr"}, 32'(dones[0].addr), 32'(v.ea));
         check({t, "_len"},  32'(dones[0].len), 32'(v.el));
         check({t, "_perr"}, 32'(dones[0].perr), 32'(v.ep));
         check({t, "_terr"}, 32'(dones[0].terr), 0);
      end
      check({t, "_beats"}, 32'(beats.size()), 32'(v.n));
      for (int k = 0; k < v.n && k < beats.size(); k++)
         check($sformatf("%s_beat%0d", t, k), 32'(beats[k]), 32'({(k == v.n - 1), pl[k]}));
      check({t, "_pkt_count"}, 32'(o_Packet_Count), 32'(v.epkt));
      check({t, "_err_count"}, 32'(o_Error_Count), 32'(v.eerr));
      if (i == 0) begin
         check({t, "_rden_run"},   32'(rd_max), 10);
         check({t, "_rden_total"}, 32'(rd_total), 10);
      end
      if (v.rmode == 1) begin
         check({t, "_fifo_max"},     32'(f_max), 2);
         check({t, "_rden_on_full"}, 32'(f_viol), 0);
      end
      ready_mode = 0;
   endtask

   task automatic timeout_seq();
      logic [7:0] a, b;
      a = 8'h5A; b = 8'hC3;
      rq.push_back(8'h12); rq.push_back(a); rq.push_back(b);
      clear_mon();
      src_en = 1'b1;
      repeat (45) step();
      check("to_done_count", 32'(dones.size()), 1);
      if (dones.size() != 0) begin
         check("to_terr",    32'(dones[0].terr), 1);
         check("to_perr",    32'(dones[0].perr), 0);
         check("to_addr",    32'(dones[0].addr), 2);
         check("to_len",     32'(dones[0].len), 4);
         check("to_latency", 32'(dones[0].cyc - last_arr), 32);
      end
      check("to_beats", 32'(beats.size()), 2);
      if (beats.size() == 2) begin
         check("to_beat0", 32'(beats[0]), 32'({1'b0, a}));
         check("to_beat1", 32'(beats[1]), 32'({1'b0, b}));
      end
      check("to_err_count", 32'(o_Error_Count), 2);
      check("to_pkt_count", 32'(o_Packet_Count), 3);
   endtask

   task automatic reset_seq();
      logic [7:0] par;
      par = 8'h22;
      rq.push_back(8'h22);
      for (int k = 0; k < 8; k++) begin
         rq.push_back(8'(8'h40 + k));
         par ^= 8'(8'h40 + k);
      end
      rq.push_back(par);
      clear_mon();
      src_en = 1'b1;
      repeat (6) step();
      check("rst_mid_no_done", 32'(dones.size()), 0);
      src_en = 1'b0;
      rq.delete();
      rst_drv = 1'b0;
      step();
      rst_drv = 1'b1;
      step();
      check_zero("rst_mid");
      repeat (40) step();
      check("rst_mid_no_done_after", 32'(dones.size()), 0);
      check("rst_mid_buf_empty", 32'(o_Payload_Valid), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog cycles=%0d required=finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0] = '{8'h22, 8, 8'h00, 0, 2'd2, 6'd8, 1'b0, 1, 0};
      vt[1] = '{8'h16, 5, 8'h01, 0, 2'd2, 6'd5, 1'b1, 1, 1};
      vt[2] = '{8'h23, 8, 8'h00, 1, 2'd3, 6'd8, 1'b0, 2, 1};
      vt[3] = '{8'h01, 0, 8'h00, 0, 2'd1, 6'd0, 1'b0, 3, 1};
      vt[4] = '{8'h0A, 2, 8'h00, 0, 2'd2, 6'd2, 1'b0, 4, 2};
      vt[5] = '{8'h21, 8, 8'h00, 1, 2'd1, 6'd8, 1'b0, 1, 0};

      reset = 1'b0;
      i_Output_Valid_Data = 1'b0;
      i_Output_Data = 8'h00;
      i_Payload_Ready = 1'b1;
      repeat (3) step();
      rst_drv = 1'b1;
      step();
      check_zero("por");

      for (int i = 0; i < 6; i++) begin
         if (i == 4) timeout_seq();
         if (i == 5) reset_seq();
         run_vec(i);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
